ram_string_reader: RTL and testbench
====================================

// Module: ram_string_reader
// PURPOSE
//   Bus initiator on the 10-bit single-port RAM: walks memory from a base address,
//   streams each word's low byte as a character over a valid/ready interface, and
//   stops at the NUL terminator (word == 0). Sits between data RAM and a char sink
//   (UART TX / display). Owns the RAM address port while busy; never writes.
// PARAMETERS
//   AW       10    RAM address width (1024 words)
//   DW       10    RAM data width
//   MAX_LEN  256   max chars streamed per string before forced stop (overrun)
// PORTS
//   clk         in   1    single clock; all state on rising edge
//   rst_n       in   1    reset, asynchronous, active-low
//   start       in   1    begin a string read; sampled only in IDLE
//   base_addr   in   AW   address of first character; sampled with start
//   address     out  AW   RAM address (to RAM address port)
//   we          out  1    RAM write enable, constant 0
//   wdata       out  DW   RAM write data, constant 0
//   rdata       in   DW   RAM read data (asynchronous read, valid same cycle)
//   char_data   out  8    character byte = registered rdata[7:0]
//   char_valid  out  1    char_data valid; held until accepted
//   char_ready  in   1    sink accepts when char_valid && char_ready
//   busy        out  1    1 in any state other than IDLE
//   done        out  1    one-cycle pulse at end of string
//   length      out  AW   chars accepted for last/current string
//   overrun     out  1    set at done if MAX_LEN hit before terminator
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, ptr=0, address=0, char_data=0,
//     char_valid=0, busy=0, done=0, length=0, overrun=0.
//   States: IDLE -> FETCH -> PRESENT -> (FETCH | FINISH) ; FETCH -> FINISH ; FINISH -> IDLE.
//   IDLE: address=ptr. start=1: ptr<=base_addr, length<=0, overrun<=0, -> FETCH.
//   FETCH: address=ptr; rdata sampled this cycle.
//     rdata==0 -> FINISH (terminator, not emitted).
//     else char_data<=rdata[7:0], char_valid<=1, -> PRESENT. rdata[9:8] ignored.
//   PRESENT: char_valid=1, char_data stable until handshake.
//     valid&&ready: char_valid<=0, ptr<=ptr+1 (mod 2^AW, 1023 wraps to 0),
//     length<=length+1; if length+1==MAX_LEN -> FINISH with overrun<=1, else -> FETCH.
//   FINISH: done=1 for exactly this cycle, -> IDLE. length/overrun hold until next start.
//   Latency: start high at edge N -> char_valid high after edge N+2; with ready tied
//     high one char every 2 cycles.
//   start while busy: ignored, no effect on ptr/length. start in FINISH: ignored.
//   char_valid never drops without a handshake except on reset.
//   Reset mid-string: all outputs return to reset values immediately; partial
//     string discarded; next start restarts cleanly.
//   we and wdata are tied 0 in every state; RAM contents never modified.
// TESTING
//   1 Reset: rst_n=0 mid-cycle -> all outputs 0 without waiting for clk edge.
//   2 RAM[3..20]="WafflesAndPancakes", RAM[21]=0; start, base=3, ready=1 ->
//     18 chars 0x57,0x61,0x66..0x73 in order, done pulse, length=18, overrun=0.
//   3 Same string, ready toggled 1-of-3 cycles -> identical byte sequence, each
//     char_data held stable while valid&&!ready, no drops/duplicates.
//   4 base=2 (RAM[2]=0) -> no char_valid, done 2 cycles after start, length=0.
//   5 RAM[1022]=0x41, RAM[1023]=0x42, RAM[0]=0x43, RAM[1]=0 -> "ABC", address
//     wraps 1023->0, length=3; second start during stream ignored.
//   6 MAX_LEN=4 on string from base=3 -> "Waff", done, length=4, overrun=1;
//     separate run: rst_n low after 2nd char -> idle, restart yields full string.

Source files
------------

// File: rtl/ram_string_reader.sv
// ---------------------------------------------------------------------------
// ram_string_reader
//
// Bus initiator on a single-port RAM with asynchronous read. Starting at
// base_addr it reads one word per character, forwards the low byte of each
// word over a valid/ready character interface, and stops at the first
// all-zero word (the NUL terminator, which is not forwarded). A string that
// reaches MAX_LEN characters without a terminator is cut short and flagged
// with overrun. The block only ever reads: we and wdata are tied low.
//
// Ports
//   clk         in   1    clock, all state on the rising edge
//   rst_n       in   1    asynchronous active-low reset
//   start       in   1    begin a string read (honoured only while idle)
//   base_addr   in   AW   address of the first character, taken with start
//   address     out  AW   RAM address
//   we          out  1    RAM write enable, always 0
//   wdata       out  DW   RAM write data, always 0
//   rdata       in   DW   RAM read data, valid in the same cycle as address
//   char_data   out  8    current character (low byte of the RAM word)
//   char_valid  out  1    char_data is valid; held until accepted
//   char_ready  in   1    sink accepts when char_valid && char_ready
//   busy        out  1    high whenever a string is being processed
//   done        out  1    one-cycle pulse when a string ends
//   length      out  AW   characters accepted for the last/current string
//   overrun     out  1    string was cut at MAX_LEN before its terminator
// ---------------------------------------------------------------------------
module ram_string_reader #(
    parameter int AW      = 10,
    parameter int DW      = 10,
    parameter int MAX_LEN = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    output logic [AW-1:0] address,
    output logic          we,
    output logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata,
    output logic [7:0]    char_data,
    output logic          char_valid,
    input  logic          char_ready,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] length,
    output logic          overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PRESENT,
        S_FINISH
    } state_t;

    // Compared one bit wider than length so MAX_LEN == 2**AW still works.
    localparam logic [AW:0] MAX_LEN_W = (AW+1)'(MAX_LEN);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] ptr;
    logic          handshake;
    logic [AW:0]   length_inc;
    logic          hit_max;

    assign handshake  = char_valid && char_ready;
    assign length_inc = {1'b0, length} + (AW+1)'(1);
    assign hit_max    = (length_inc == MAX_LEN_W);

    // The RAM address simply follows the read pointer in every state; in idle
    // it parks on the last pointer value (0 after reset).
    assign address = ptr;
    assign we      = 1'b0;
    assign wdata   = '0;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_FINISH);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch
        // is inferred.
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                // An all-zero word (upper bits included) terminates the string.
                if (rdata == '0) state_next = S_FINISH;
                else             state_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (handshake) state_next = hit_max ? S_FINISH : S_FETCH;
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            char_data  <= '0;
            char_valid <= 1'b0;
            length     <= '0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr     <= base_addr;
                        length  <= '0;
                        overrun <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (rdata != '0) begin
                        char_data  <= rdata[7:0];
                        char_valid <= 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (handshake) begin
                        char_valid <= 1'b0;
                        ptr        <= ptr + AW'(1);   // wraps at the top of RAM
                        length     <= length_inc[AW-1:0];
                        if (hit_max) overrun <= 1'b1;
                    end
                end
                default: begin
                    // FINISH: length and overrun hold for the sink to read.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_string_reader.sv
// ---------------------------------------------------------------------------
// tb_ram_string_reader
//
// Directed bench for ram_string_reader. Two instances share one RAM model:
// u_dut uses the default MAX_LEN, u_dut4 uses MAX_LEN=4 to reach overrun.
// sel chooses which instance the stream collector watches.
// ---------------------------------------------------------------------------
module tb_ram_string_reader;

    localparam int AW = 10;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start1 = 1'b0;
    logic          start2 = 1'b0;
    logic          char_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;

    logic [AW-1:0] address1, address2;
    logic          we1, we2;
    logic [DW-1:0] wdata1, wdata2;
    logic [DW-1:0] rdata1, rdata2;
    logic [7:0]    char_data1, char_data2;
    logic          char_valid1, char_valid2;
    logic          busy1, busy2;
    logic          done1, done2;
    logic [AW-1:0] length1, length2;
    logic          overrun1, overrun2;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    assign rdata1 = mem[address1];
    assign rdata2 = mem[address2];

    ram_string_reader #(.AW(AW), .DW(DW), .MAX_LEN(256)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .base_addr(base_addr),
        .address(address1), .we(we1), .wdata(wdata1), .rdata(rdata1),
        .char_data(char_data1), .char_valid(char_valid1), .char_ready(char_ready),
        .busy(busy1), .done(done1), .length(length1), .overrun(overrun1)
    );

    ram_string_reader #(.AW(AW), .DW(DW), .MAX_LEN(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start2), .base_addr(base_addr),
        .address(address2), .we(we2), .wdata(wdata2), .rdata(rdata2),
        .char_data(char_data2), .char_valid(char_valid2), .char_ready(char_ready),
        .busy(busy2), .done(done2), .length(length2), .overrun(overrun2)
    );

    // Observation mux: sel=0 watches u_dut, sel=1 watches u_dut4.
    logic          sel = 1'b0;
    logic [AW-1:0] o_address, o_length;
    logic [7:0]    o_data;
    logic          o_valid, o_busy, o_done, o_overrun, o_we;
    logic [DW-1:0] o_wdata;
    assign o_address = sel ? address2    : address1;
    assign o_length  = sel ? length2     : length1;
    assign o_data    = sel ? char_data2  : char_data1;
    assign o_valid   = sel ? char_valid2 : char_valid1;
    assign o_busy    = sel ? busy2       : busy1;
    assign o_done    = sel ? done2       : done1;
    assign o_overrun = sel ? overrun2    : overrun1;
    assign o_we      = sel ? we2         : we1;
    assign o_wdata   = sel ? wdata2      : wdata1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got [$];
    bit         saw_done;
    bit         saw_wrap;

    string waffles = "WafflesAndPancakes";

    // Drive start for one edge, then sample #1 after that edge.
    task automatic kick(input bit which, input logic [AW-1:0] b);
        base_addr = b;
        if (which) start2 = 1'b1;
        else       start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Collect accepted characters until done is seen or the budget expires.
    // ready_mode 0: ready always high; 1: ready high one cycle in three.
    // extra_start_cyc >= 0 raises start on u_dut (base 3) during that cycle.
    task automatic stream(input int ready_mode, input int budget, input int extra_start_cyc);
        bit            hold;
        logic [7:0]    held;
        logic [AW-1:0] prev_addr;
        got.delete();
        saw_done  = 1'b0;
        saw_wrap  = 1'b0;
        hold      = 1'b0;
        held      = '0;
        prev_addr = o_address;
        for (int c = 0; c < budget && !saw_done; c++) begin
            char_ready = (ready_mode == 0) ? 1'b1 : ((c % 3) == 2);
            if (c == extra_start_cyc) begin
                start1    = 1'b1;
                base_addr = 10'd3;
            end else begin
                start1 = 1'b0;
            end
            if (hold) begin
                n_checks++;
                if (o_valid !== 1'b1 || o_data !== held) begin
                    n_fail++;
                    $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h",
                             o_valid, o_data, held);
                end
            end
            n_checks++;
            if (o_we !== 1'b0 || o_wdata !== '0) begin
                n_fail++;
                $display("FAIL ram_write: we=%b wdata=%h, required 0/0", o_we, o_wdata);
            end
            if (prev_addr == 10'd1023 && o_address == 10'd0) saw_wrap = 1'b1;
            prev_addr = o_address;
            if (o_done === 1'b1)                 saw_done = 1'b1;
            else if (o_valid && char_ready)      got.push_back(o_data);
            hold = o_valid && !char_ready;
            held = o_data;
            @(posedge clk); #1;
        end
        start1     = 1'b0;
        char_ready = 1'b0;
        n_checks++;
        if (!saw_done) begin
            n_fail++;
            $display("FAIL stream_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({o_valid, o_busy, o_done, o_overrun, o_we} !== 5'b0 ||
            o_address !== '0 || o_data !== '0 || o_length !== '0 || o_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b busy=%b done=%b ovr=%b addr=%h data=%h len=%0d, required all 0",
                     o_valid, o_busy, o_done, o_overrun, o_address, o_data, o_length);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b valid=%b done=%b, required 0/0/0",
                     o_busy, o_valid, o_done);
        end
    endtask

    task automatic test_basic_string();
        sel = 1'b0;
        kick(1'b0, 10'd3);
        n_checks++;
        if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_cycle: busy=%b valid=%b, required 1/0", o_busy, o_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h57) begin
            n_fail++;
            $display("FAIL first_char: valid=%b data=%h, required 1/57", o_valid, o_data);
        end
        stream(0, 100, -1);
        n_checks++;
        if (got.size() != 18) begin
            n_fail++;
            $display("FAIL basic_count: got %0d chars, required 18", got.size());
        end
        for (int i = 0; i < 18 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== waffles[i]) begin
                n_fail++;
                $display("FAIL basic_char[%0d]: got %h, required %h", i, got[i], waffles[i]);
            end
        end
        n_checks++;
        if (o_length !== 10'd18 || o_overrun !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: len=%0d ovr=%b busy=%b, required 18/0/0",
                     o_length, o_overrun, o_busy);
        end
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        kick(1'b0, 10'd3);
        stream(1, 300, -1);
        n_checks++;
        if (got.size() != 18) begin
            n_fail++;
            $display("FAIL bp_count: got %0d chars, required 18", got.size());
        end
        for (int i = 0; i < 18 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== waffles[i]) begin
                n_fail++;
                $display("FAIL bp_char[%0d]: got %h, required %h", i, got[i], waffles[i]);
            end
        end
        n_checks++;
        if (o_length !== 10'd18 || o_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: len=%0d ovr=%b, required 18/0", o_length, o_overrun);
        end
    endtask

    task automatic test_empty_string();
        sel = 1'b0;
        kick(1'b0, 10'd2);
        n_checks++;
        if (o_done !== 1'b0 || o_valid !== 1'b0 || o_length !== 10'd0) begin
            n_fail++;
            $display("FAIL empty_fetch: done=%b valid=%b len=%0d, required 0/0/0",
                     o_done, o_valid, o_length);
        end
        @(posedge clk); #1;
        n_checks++;
        if (o_done !== 1'b1 || o_valid !== 1'b0 || o_length !== 10'd0) begin
            n_fail++;
            $display("FAIL empty_done: done=%b valid=%b len=%0d, required 1/0/0",
                     o_done, o_valid, o_length);
        end
        @(posedge clk); #1;
        n_checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_idle: done=%b busy=%b, required 0/0", o_done, o_busy);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp [3];
        exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
        sel = 1'b0;
        kick(1'b0, 10'd1022);
        stream(0, 100, 2);
        n_checks++;
        if (got.size() != 3) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d chars, required 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL wrap_char[%0d]: got %h, required %h", i, got[i], exp[i]);
            end
        end
        n_checks++;
        if (!saw_wrap) begin
            n_fail++;
            $display("FAIL wrap_address: address never went 1023 -> 0, required wrap");
        end
        n_checks++;
        if (o_length !== 10'd3 || o_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_end: len=%0d ovr=%b, required 3/0", o_length, o_overrun);
        end
    endtask

    task automatic test_overrun();
        sel = 1'b1;
        kick(1'b1, 10'd3);
        stream(0, 100, -1);
        n_checks++;
        if (got.size() != 4) begin
            n_fail++;
            $display("FAIL ovr_count: got %0d chars, required 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== waffles[i]) begin
                n_fail++;
                $display("FAIL ovr_char[%0d]: got %h, required %h", i, got[i], waffles[i]);
            end
        end
        n_checks++;
        if (o_length !== 10'd4 || o_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_end: len=%0d ovr=%b, required 4/1", o_length, o_overrun);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_string();
        sel = 1'b0;
        kick(1'b0, 10'd3);
        char_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        char_ready = 1'b0;
        n_checks++;
        if (o_length !== 10'd2 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_progress: len=%0d busy=%b, required 2/1", o_length, o_busy);
        end
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_valid, o_busy, o_done, o_overrun} !== 4'b0 ||
            o_address !== '0 || o_data !== '0 || o_length !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b busy=%b done=%b ovr=%b addr=%h data=%h len=%0d, required all 0",
                     o_valid, o_busy, o_done, o_overrun, o_address, o_data, o_length);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        kick(1'b0, 10'd3);
        @(posedge clk); #1;
        stream(0, 100, -1);
        n_checks++;
        if (got.size() != 18) begin
            n_fail++;
            $display("FAIL restart_count: got %0d chars, required 18", got.size());
        end
        for (int i = 0; i < 18 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== waffles[i]) begin
                n_fail++;
                $display("FAIL restart_char[%0d]: got %h, required %h", i, got[i], waffles[i]);
            end
        end
        n_checks++;
        if (o_length !== 10'd18 || o_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_end: len=%0d ovr=%b, required 18/0", o_length, o_overrun);
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        // Odd-position characters carry junk in bits [9:8], which must be ignored.
        for (int i = 0; i < 18; i++) begin
            mem[3 + i] = {(i % 2 == 1) ? 2'b10 : 2'b00, waffles[i]};
        end
        mem[21]   = '0;
        mem[2]    = '0;
        mem[1022] = 10'h041;
        mem[1023] = 10'h342;
        mem[0]    = 10'h043;
        mem[1]    = '0;

        test_reset();
        test_basic_string();
        test_backpressure();
        test_empty_string();
        test_wrap();
        test_overrun();
        test_reset_mid_string();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
